id_ex_stage: RTL and testbench

//  ID/EX pipeline stage directly upstream of the ALU. Registers one decoded

---
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with MEM/WB operand forwarding and WB snoop
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic              alu_src_d,
  input  logic [2:0]        alu_control_d,
  input  logic              reg_write_d,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   SrcA,
  output logic [XLEN-1:0]   SrcB,
  output logic [2:0]        ALUControl,
  output logic [XLEN-1:0]   write_data_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              reg_write_e,
  output logic              illegal_op
);

  logic              valid_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   op_a_q, op_b_q, imm_q;
  logic              alu_src_q, reg_write_q;
  logic [2:0]        ctrl_q;

  logic              capture, drain;
  logic              wb_hit_a_d, wb_hit_b_d, wb_hit_a_q, wb_hit_b_q;
  logic              mem_hit_a_q, mem_hit_b_q;
  logic [XLEN-1:0]   fwd_a, fwd_b;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign drain    = valid_q && out_ready;

  // Hits against incoming indices cover an RF write landing in the same cycle as the read.
  assign wb_hit_a_d  = wb_reg_write && (wb_rd == rs1_d) && (rs1_d != '0);
  assign wb_hit_b_d  = wb_reg_write && (wb_rd == rs2_d) && (rs2_d != '0);
  assign wb_hit_a_q  = wb_reg_write && (wb_rd == rs1_q) && (rs1_q != '0);
  assign wb_hit_b_q  = wb_reg_write && (wb_rd == rs2_q) && (rs2_q != '0);
  assign mem_hit_a_q = mem_reg_write && (mem_rd == rs1_q) && (rs1_q != '0);
  assign mem_hit_b_q = mem_reg_write && (mem_rd == rs2_q) && (rs2_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      ctrl_q      <= 3'b000;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q <= 1'b1;
      end else if (drain) begin
        valid_q <= 1'b0;
      end

      if (capture) begin
        rs1_q       <= rs1_d;
        rs2_q       <= rs2_d;
        rd_q        <= rd_d;
        imm_q       <= imm_d;
        alu_src_q   <= alu_src_d;
        reg_write_q <= reg_write_d;
        ctrl_q      <= alu_control_d;
        op_a_q      <= wb_hit_a_d ? wb_result : rd1_d;
        op_b_q      <= wb_hit_b_d ? wb_result : rd2_d;
      end else if (valid_q) begin
        // Keep held operands architecturally current while stalled.
        if (wb_hit_a_q) op_a_q <= wb_result;
        if (wb_hit_b_q) op_b_q <= wb_result;
      end
    end
  end

  always_comb begin
    fwd_a = op_a_q;
    fwd_b = op_b_q;
    if (mem_hit_a_q) begin
      fwd_a = mem_result;
    end else if (wb_hit_a_q) begin
      fwd_a = wb_result;
    end
    if (mem_hit_b_q) begin
      fwd_b = mem_result;
    end else if (wb_hit_b_q) begin
      fwd_b = wb_result;
    end
  end

  assign out_valid    = valid_q;
  assign SrcA         = fwd_a;
  assign SrcB         = alu_src_q ? imm_q : fwd_b;
  assign write_data_e = fwd_b;
  assign ALUControl   = ctrl_q;
  assign rd_e         = rd_q;
  assign reg_write_e  = valid_q & reg_write_q;
  assign illegal_op   = valid_q && ((ctrl_q == 3'b100) || (ctrl_q == 3'b110) || (ctrl_q == 3'b111));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against an architectural register-file model
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] rd1_d, rd2_d, imm_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        alu_src_d, reg_write_d;
  logic [2:0]  alu_control_d;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        out_valid, out_ready;
  logic [31:0] SrcA, SrcB, write_data_e;
  logic [2:0]  ALUControl;
  logic [4:0]  rd_e;
  logic        reg_write_e, illegal_op;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .imm_d(imm_d), .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
    .reg_write_d(reg_write_d), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .write_data_e(write_data_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        asrc;
    logic [2:0]  ctrl;
    logic        rw;
  } rec_t;

  typedef struct packed {
    logic        rst_n, v, fl, ordy;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        asrc;
    logic [2:0]  ctrl;
    logic        rw;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } stim_t;

  rec_t        q[$];
  logic [31:0] rf[32];
  stim_t       s;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t t;
    t = '0;
    t.rst_n = 1'b1;
    t.ordy = 1'b1;
    return t;
  endfunction

  // Architectural value of a source register as the ALU should see it this cycle.
  function automatic logic [31:0] arch_val(input logic [4:0] rs);
    if (rs == 5'd0) return rf[0];
    if (mem_reg_write && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd == rs) return wb_result;
    return rf[rs];
  endfunction

  task automatic apply();
    rst_n = s.rst_n; in_valid = s.v; flush = s.fl; out_ready = s.ordy;
    rs1_d = s.rs1; rs2_d = s.rs2; rd_d = s.rd; imm_d = s.imm;
    alu_src_d = s.asrc; alu_control_d = s.ctrl; reg_write_d = s.rw;
    rd1_d = rf[s.rs1]; rd2_d = rf[s.rs2];
    mem_reg_write = s.mw; mem_rd = s.mrd; mem_result = s.mres;
    wb_reg_write = s.ww; wb_rd = s.wrd; wb_result = s.wres;
  endtask

  // One clock cycle: drive after the edge, then account for what the next edge does.
  task automatic step();
    rec_t r;
    @(posedge clk);
    #1;
    apply();
    @(negedge clk);
    #1;
    if (!s.rst_n || s.fl) begin
      q.delete();
    end else if (s.v && (s.ordy || q.size() == 0)) begin
      r.rs1 = s.rs1; r.rs2 = s.rs2; r.rd = s.rd; r.imm = s.imm;
      r.asrc = s.asrc; r.ctrl = s.ctrl; r.rw = s.rw;
      q.push_back(r);
    end
    if (s.ww && s.wrd != 5'd0) rf[s.wrd] = s.wres;
  endtask

  rec_t        e;
  logic [31:0] ea, eb;

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0) || out_ready});
      if (q.size() != 0) begin
        e  = q[0];
        ea = arch_val(e.rs1);
        eb = arch_val(e.rs2);
        check("srca", SrcA, ea);
        check("srcb", SrcB, e.asrc ? e.imm : eb);
        check("write_data_e", write_data_e, eb);
        check("alucontrol", {29'd0, ALUControl}, {29'd0, e.ctrl});
        check("rd_e", {27'd0, rd_e}, {27'd0, e.rd});
        check("reg_write_e", {31'd0, reg_write_e}, {31'd0, e.rw});
        check("illegal_op", {31'd0, illegal_op},
              {31'd0, (e.ctrl == 3'd4) || (e.ctrl == 3'd6) || (e.ctrl == 3'd7)});
        if (out_ready) void'(q.pop_front());
      end else begin
        check("idle_reg_write_e", {31'd0, reg_write_e}, 32'd0);
        check("idle_illegal_op", {31'd0, illegal_op}, 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd3; rf[4] = 32'h1234;

    s = idle(); s.rst_n = 1'b0; s.v = 1'b1; s.rs1 = 5'd1; s.rs2 = 5'd2;
    apply();
    mon_en = 1'b1;
    step(); step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_srca", SrcA, 32'd0);
    check("rst_srcb", SrcB, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    s = idle(); step();

    s = idle(); s.v = 1; s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3; s.rw = 1; step();
    s = idle(); step();
    check("add_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_srca", SrcA, 32'd5);
    check("add_srcb", SrcB, 32'd3);
    check("add_ctrl", {29'd0, ALUControl}, 32'd0);

    s = idle(); s.v = 1; s.rs1 = 5'd7; step();
    s = idle(); s.ordy = 0; s.mw = 1; s.mrd = 5'd7; s.mres = 32'h11;
    s.ww = 1; s.wrd = 5'd7; s.wres = 32'h22; step();
    check("fwd_mem_wins", SrcA, 32'h11);
    s.mw = 0; step();
    check("fwd_wb", SrcA, 32'h22);
    s = idle(); step();
    s = idle(); s.v = 1; s.rs1 = 5'd0; step();
    s = idle(); s.ordy = 0; s.mw = 1; s.mrd = 5'd0; s.mres = 32'h11;
    s.ww = 1; s.wrd = 5'd0; s.wres = 32'h22; step();
    check("fwd_x0", SrcA, 32'd0);
    s = idle(); step();

    s = idle(); s.v = 1; s.rs1 = 5'd1; s.rs2 = 5'd4; step();
    s = idle(); s.ordy = 0; step();
    check("stall_c1_wd", write_data_e, 32'h1234);
    s.ww = 1; s.wrd = 5'd4; s.wres = 32'hABCD; step();
    check("stall_c2_wd", write_data_e, 32'hABCD);
    s.ww = 0; step();
    check("stall_c3_wd", write_data_e, 32'hABCD);
    check("stall_c3_srcb", SrcB, 32'hABCD);
    s.ordy = 1; step();
    check("stall_after_wd", write_data_e, 32'hABCD);

    for (int i = 0; i < 4; i++) begin
      s = idle(); s.v = 1; s.rs1 = 5'(i); s.ctrl = 3'(i); step();
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    end
    s = idle(); s.v = 1; s.ctrl = 3'd5; s.ordy = 0; step();
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("hold_ctrl", {29'd0, ALUControl}, 32'd3);
    step();
    check("hold_ctrl2", {29'd0, ALUControl}, 32'd3);
    s = idle(); step();

    s = idle(); s.v = 1; s.rs1 = 5'd1; step();
    s = idle(); s.v = 1; s.fl = 1; s.ordy = 0; step();
    s = idle(); step();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    s = idle(); s.v = 1; s.ctrl = 3'b110; step();
    s = idle(); s.ordy = 0; step();
    check("illegal_set", {31'd0, illegal_op}, 32'd1);
    s.ordy = 1; step();
    s = idle(); step();
    check("illegal_clear", {31'd0, illegal_op}, 32'd0);

    repeat (2000) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 199) != 0);
      s.v     = ($urandom_range(0, 9) < 7);
      s.fl    = ($urandom_range(0, 19) == 0);
      s.ordy  = ($urandom_range(0, 9) < 7);
      s.rs1   = 5'($urandom_range(0, 7));
      s.rs2   = 5'($urandom_range(0, 7));
      s.rd    = 5'($urandom);
      s.imm   = $urandom;
      s.asrc  = 1'($urandom);
      s.ctrl  = 3'($urandom);
      s.rw    = 1'($urandom);
      s.mw    = ($urandom_range(0, 9) < 4);
      s.mrd   = 5'($urandom_range(0, 7));
      s.mres  = $urandom;
      s.ww    = ($urandom_range(0, 9) < 4);
      s.wrd   = 5'($urandom_range(0, 7));
      s.wres  = $urandom;
      step();
    end

    s = idle(); step(); step();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
